// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int UART_DATA_BITS = 8;

  // Clocks per bit, rounded to nearest.
  function automatic int uart_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == FULL_LEVEL);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  // Head is forced to zero while empty so the output never shows stale data.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_stream.sv
// Oversampled 8N1 UART receiver with start-bit validation, sticky error flags and a buffered byte stream.
// Stream handshake: a byte leaves the FIFO on every clk_clk edge where rx_valid and rx_ready are both high.
module uart_rx_stream
  import uart_pkg::*;
#(
  parameter int  CLK_HZ     = 50_000_000,
  parameter int  BAUD       = 115200,
  parameter int  DIV        = uart_div(CLK_HZ, BAUD),
  parameter int  FIFO_DEPTH = 16,
  localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset_n,
  input  logic                      rxd,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      rx_busy,
  output logic                      frame_err,
  output logic                      overrun,
  input  logic                      err_clr,
  output logic [LW-1:0]             fifo_level
);

  localparam int CW = $clog2(DIV);
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(DIV - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(UART_DATA_BITS - 1);

  logic                      sync1, sync2, prev;
  rx_state_t                 state;
  logic [CW-1:0]             cnt;
  logic [BW-1:0]             bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      tick, fall, push, pop, stop_bad, full, empty;

  assign tick     = (cnt == '0);
  assign fall     = prev & ~sync2;
  assign pop      = rx_valid & rx_ready;
  assign push     = (state == STOP) & tick & sync2;
  assign stop_bad = (state == STOP) & tick & ~sync2;
  assign rx_valid = ~empty;
  assign rx_busy  = (state != IDLE);

  // Idle-high reset values keep reset release from looking like a start edge.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= rxd;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fall) begin
            cnt   <= HALF_LOAD;
            state <= START;
          end
        end
        START: begin
          if (!tick) begin
            cnt <= cnt - 1'b1;
          end else if (!sync2) begin
            cnt     <= BIT_LOAD;
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (!tick) begin
            cnt <= cnt - 1'b1;
          end else begin
            shreg <= {sync2, shreg[UART_DATA_BITS-1:1]};
            cnt   <= BIT_LOAD;
            if (bit_idx == LAST_BIT) state <= STOP;
            else bit_idx <= bit_idx + 1'b1;
          end
        end
        STOP: begin
          if (!tick) cnt <= cnt - 1'b1;
          else state <= sync2 ? IDLE : BREAK;
        end
        BREAK: begin
          if (sync2) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A set in the same cycle as err_clr wins.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (stop_bad)     frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (push && full && !pop) overrun <= 1'b1;
      else if (err_clr)         overrun <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH(UART_DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk_clk),
    .rst_n  (reset_reset_n),
    .push   (push),
    .wr_data(shreg),
    .pop    (pop),
    .rd_data(rx_data),
    .full   (full),
    .empty  (empty),
    .level  (fifo_level)
  );

endmodule

// File: tb/tb_uart_rx_stream.sv
// Directed bench for uart_rx_stream: serial frame driver, byte-order model queue and per-cycle stream checker.
module tb_uart_rx_stream;

  localparam int CLK_HZ  = 1_000_000;
  localparam int BAUD    = 62_500;
  localparam int DIV     = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int DEPTH   = 16;
  localparam int LW      = $clog2(DEPTH) + 1;
  localparam int LATENCY = 2 + DIV / 2 + 9 * DIV + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rxd = 1'b1;
  logic          rx_ready = 1'b0;
  logic          err_clr = 1'b0;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_busy;
  logic          frame_err;
  logic          overrun;
  logic [LW-1:0] fifo_level;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic       exp_frame_err = 1'b0;
  logic       exp_overrun   = 1'b0;
  logic       pop_at_stop   = 1'b0;

  int   lat;
  int   t_drop;
  logic busy_seen;
  logic pulse_ok;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  uart_rx_stream #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .rxd          (rxd),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_busy      (rx_busy),
    .frame_err    (frame_err),
    .overrun      (overrun),
    .err_clr      (err_clr),
    .fifo_level   (fifo_level)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called on a negedge; leaves the line at the stop-bit level.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    rxd = stop;
    if (stop) begin
      if (exp_q.size() >= DEPTH && !pop_at_stop) exp_overrun = 1'b1;
      else exp_q.push_back(b);
    end else begin
      exp_frame_err = 1'b1;
    end
    if (pop_at_stop) begin
      // Stop sample lands DIV/2+3 edges into the stop bit.
      repeat (DIV / 2 + 2) @(negedge clk);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      repeat (DIV - DIV / 2 - 3) @(negedge clk);
    end else begin
      repeat (DIV) @(negedge clk);
    end
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_frame_err = 1'b0;
    exp_overrun   = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_frame_err"}, int'(frame_err), int'(exp_frame_err));
    check({tag, "_overrun"}, int'(overrun), int'(exp_overrun));
  endtask

  // ---------------- scoreboard / compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        check("valid_vs_level", int'(rx_valid), int'(fifo_level != '0));
        check("level_bound", int'(int'(fifo_level) <= exp_q.size()), 1);
        if (rx_valid) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_byte: got 0x%0h, expected no byte", rx_data);
          end else begin
            check("rx_data_head", int'(rx_data), int'(exp_q[0]));
            if (rx_ready) begin
              got_q.push_back(rx_data);
              void'(exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  // ---------------- directed tests ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("rst_rx_data", int'(rx_data), 0);
    check("rst_rx_valid", int'(rx_valid), 0);
    check("rst_rx_busy", int'(rx_busy), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_fifo_level", int'(fifo_level), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single byte with consumer always ready.
    rx_ready = 1'b1;
    fork
      send_frame(8'h55, 1'b1);
      begin
        lat = 0;
        while (lat < 4 * LATENCY) begin
          @(posedge clk);
          lat++;
          #1;
          if (rx_valid) break;
        end
        @(posedge clk);
        #1;
        pulse_ok = ~rx_valid;
      end
    join
    check("single_latency", lat, LATENCY);
    check("single_pulse_1cyc", int'(pulse_ok), 1);
    repeat (DIV) @(negedge clk);
    check("single_count", got_q.size(), 1);
    if (got_q.size() > 0) check("single_byte", int'(got_q[0]), 'h55);
    check_flags("single");

    // Start-bit glitch shorter than half a bit.
    got_q.delete();
    fork
      begin
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
      end
      begin
        busy_seen = 1'b0;
        t_drop = 0;
        while (t_drop < 20 * DIV) begin
          @(posedge clk);
          t_drop++;
          #1;
          if (rx_busy) busy_seen = 1'b1;
          else if (busy_seen) break;
        end
      end
    join
    check("glitch_busy_seen", int'(busy_seen), 1);
    check("glitch_busy_drop", t_drop, 3 + DIV / 2);
    repeat (2 * DIV) @(negedge clk);
    check("glitch_level", int'(fifo_level), 0);
    check("glitch_count", got_q.size(), 0);
    check_flags("glitch");

    // Framing error, held-low break, then a clean frame.
    send_frame(8'hA5, 1'b0);
    repeat (20 * DIV) @(negedge clk);
    check("break_busy", int'(rx_busy), 1);
    check("break_frame_err", int'(frame_err), 1);
    rxd = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    check("break_released", int'(rx_busy), 0);
    send_frame(8'h3C, 1'b1);
    repeat (DIV) @(negedge clk);
    check("framing_count", got_q.size(), 1);
    if (got_q.size() > 0) check("framing_byte", int'(got_q[0]), 'h3C);
    check_flags("framing");
    pulse_err_clr();
    check("framing_cleared", int'(frame_err), 0);

    // Overrun: 17 back-to-back frames with the consumer stalled.
    rx_ready = 1'b0;
    got_q.delete();
    for (int b = 0; b < 17; b++) send_frame(8'(b), 1'b1);
    repeat (DIV) @(negedge clk);
    check("ovr_level", int'(fifo_level), 16);
    check("ovr_flag", int'(overrun), 1);
    check("ovr_head", int'(rx_data), 'h00);
    check_flags("ovr");
    pulse_err_clr();
    check("ovr_cleared", int'(overrun), 0);

    // Full FIFO with a pop in the stop-sample cycle of the next frame.
    pop_at_stop = 1'b1;
    send_frame(8'h20, 1'b1);
    pop_at_stop = 1'b0;
    repeat (DIV) @(negedge clk);
    check("fullpop_level", int'(fifo_level), 16);
    check("fullpop_overrun", int'(overrun), 0);
    rx_ready = 1'b1;
    for (int i = 0; i < 4 * DEPTH && rx_valid; i++) @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
    check("drain_empty", int'(rx_valid), 0);
    check("drain_count", got_q.size(), 17);
    if (got_q.size() == 17) begin
      for (int i = 0; i < 16; i++) check("drain_order", int'(got_q[i]), i);
      check("drain_last", int'(got_q[16]), 'h20);
    end

    // Reset in the middle of bit 4 of 0x96, then a clean 0xC3.
    got_q.delete();
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = (i == 1 || i == 2) ? 1'b1 : 1'b0;
      repeat (DIV) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (DIV / 2) @(negedge clk);
    check("midframe_busy", int'(rx_busy), 1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_rx_data", int'(rx_data), 0);
    check("midrst_rx_valid", int'(rx_valid), 0);
    check("midrst_rx_busy", int'(rx_busy), 0);
    check("midrst_frame_err", int'(frame_err), 0);
    check("midrst_overrun", int'(overrun), 0);
    check("midrst_level", int'(fifo_level), 0);
    exp_q.delete();
    rst_n = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    rx_ready = 1'b1;
    send_frame(8'hC3, 1'b1);
    repeat (2 * DIV) @(negedge clk);
    check("postrst_count", got_q.size(), 1);
    if (got_q.size() > 0) check("postrst_byte", int'(got_q[0]), 'hC3);
    check("postrst_frame_err", int'(frame_err), 0);
    check("postrst_overrun", int'(overrun), 0);
    check("model_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
